// File: rtl/dm_stage_ctrl.sv
// DM-stage controller: registers the EX load/store, serves word RAM in one cycle,
// and runs multi-cycle I/O bus accesses with a stall, ack handshake and timeout abort.
module dm_stage_ctrl #(
   parameter int          DM_ADDR_W = 14,
   parameter logic [15:0] IO_BASE   = 16'hC000,
   parameter int          TIMEOUT   = 255,
   parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dm_re_EX,
   input  logic        dm_we_EX,
   input  logic [31:0] dm_addr_EX,
   input  logic [31:0] dm_wrt_data_EX,
   output logic        dm_re_EX_DM,
   output logic [31:0] dm_rd_data_EX_DM,
   output logic        stall_DM,
   output logic        io_req,
   output logic        io_we,
   output logic [15:0] io_addr,
   output logic [31:0] io_wdata,
   input  logic        io_rdy,
   input  logic [31:0] io_rdata,
   output logic        io_err
);

   typedef enum logic [1:0] {S_IDLE, S_IO_WAIT, S_IO_DONE} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [31:0]            r_ram [0:(1<<DM_ADDR_W)-1];
   logic [15:0]            r_cnt;
   logic [31:0]            r_rd_data;
   logic                   r_re;
   logic                   r_io_req;
   logic                   r_io_we;
   logic [15:0]            r_io_addr;
   logic [31:0]            r_io_wdata;
   logic                   r_io_err;

   logic                   w_accept;
   logic                   w_is_io;
   logic                   w_io_start;
   logic                   w_ram_we;
   logic                   w_ram_re;
   logic [15:0]            w_cnt_nxt;
   logic                   w_timeout;
   logic [DM_ADDR_W-1:0]   w_idx;
   logic                   w_unused;

   assign w_accept   = (r_state != S_IO_WAIT);
   assign w_is_io    = (dm_addr_EX[15:0] >= IO_BASE);
   assign w_idx      = dm_addr_EX[DM_ADDR_W-1:0];
   assign w_io_start = w_accept & (dm_re_EX | dm_we_EX) & w_is_io;
   assign w_ram_we   = w_accept & dm_we_EX & ~w_is_io & ~rst;
   assign w_ram_re   = dm_re_EX & ~dm_we_EX & ~w_is_io;
   assign w_cnt_nxt  = r_cnt + 16'd1;
   // An ack in the final wait cycle wins over the timeout.
   assign w_timeout  = (r_state == S_IO_WAIT) & ~io_rdy & (w_cnt_nxt == 16'(TIMEOUT));
   assign w_unused   = &{1'b0, dm_addr_EX[31:16]};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_IO_DONE: w_state_nxt = w_io_start ? S_IO_WAIT : S_IDLE;
         S_IO_WAIT:         if (io_rdy || w_timeout) w_state_nxt = S_IO_DONE;
         default:           w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[w_idx] <= dm_wrt_data_EX;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_rd_data  <= '0;
         r_re       <= 1'b0;
         r_io_req   <= 1'b0;
         r_io_we    <= 1'b0;
         r_io_addr  <= '0;
         r_io_wdata <= '0;
         r_io_err   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_io_err <= 1'b0;
         if (w_accept) begin
            r_re      <= dm_re_EX & ~dm_we_EX;
            r_rd_data <= w_ram_re ? r_ram[w_idx] : 32'd0;
            r_cnt     <= '0;
            if (w_io_start) begin
               r_io_req   <= 1'b1;
               r_io_we    <= dm_we_EX;
               r_io_addr  <= dm_addr_EX[15:0];
               r_io_wdata <= dm_wrt_data_EX;
            end
         end else begin
            r_cnt <= w_cnt_nxt;
            if (io_rdy) begin
               r_rd_data <= r_io_we ? 32'd0 : io_rdata;
               r_io_req  <= 1'b0;
               r_io_we   <= 1'b0;
            end else if (w_timeout) begin
               r_rd_data <= ERR_DATA;
               r_io_err  <= 1'b1;
               r_io_req  <= 1'b0;
               r_io_we   <= 1'b0;
            end
         end
      end
   end

   assign stall_DM         = (r_state == S_IO_WAIT);
   assign dm_re_EX_DM      = r_re;
   assign dm_rd_data_EX_DM = r_rd_data;
   assign io_req           = r_io_req;
   assign io_we            = r_io_we;
   assign io_addr          = r_io_addr;
   assign io_wdata         = r_io_wdata;
   assign io_err           = r_io_err;

endmodule

// File: tb/tb_dm_stage_ctrl.sv
// Bench for dm_stage_ctrl: directed loads/stores to RAM and I/O; load results checked by a scoreboard monitor.
module tb_dm_stage_ctrl;
   localparam int TO = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dm_re_EX = 1'b0;
   logic        dm_we_EX = 1'b0;
   logic [31:0] dm_addr_EX = '0;
   logic [31:0] dm_wrt_data_EX = '0;
   logic        dm_re_EX_DM;
   logic [31:0] dm_rd_data_EX_DM;
   logic        stall_DM;
   logic        io_req;
   logic        io_we;
   logic [15:0] io_addr;
   logic [31:0] io_wdata;
   logic        io_rdy = 1'b0;
   logic [31:0] io_rdata = '0;
   logic        io_err;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   dm_stage_ctrl #(.DM_ADDR_W(14), .IO_BASE(16'hC000), .TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)) dut (
      .clk(clk), .rst(rst),
      .dm_re_EX(dm_re_EX), .dm_we_EX(dm_we_EX), .dm_addr_EX(dm_addr_EX), .dm_wrt_data_EX(dm_wrt_data_EX),
      .dm_re_EX_DM(dm_re_EX_DM), .dm_rd_data_EX_DM(dm_rd_data_EX_DM), .stall_DM(stall_DM),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_rdy(io_rdy), .io_rdata(io_rdata), .io_err(io_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic re, input logic we, input logic [31:0] addr, input logic [31:0] wd);
      dm_re_EX = re; dm_we_EX = we; dm_addr_EX = addr; dm_wrt_data_EX = wd;
   endtask

   // Load results are compared whenever the DUT presents one.
   always @(negedge clk) begin
      if (!rst && !stall_DM && dm_re_EX_DM === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL load_result: got 0x%08h with no expected entry", dm_rd_data_EX_DM);
         end else begin
            chk("load_result", dm_rd_data_EX_DM, exp_q.pop_front());
         end
      end
   end

   task automatic ram_op(input logic re, input logic we, input logic [31:0] addr, input logic [31:0] wd);
      drive(re, we, addr, wd);
      tick();
      chk("ram_no_stall", 32'(stall_DM), 32'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic io_access(input logic re, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input int rdy_at, input logic [31:0] rdata, input int exp_stall, input logic exp_err);
      int n;
      drive(re, we, addr, wd);
      tick();
      chk("io_req_rise", 32'(io_req), 32'd1);
      chk("io_addr", 32'(io_addr), 32'(addr[15:0]));
      chk("io_we", 32'(io_we), 32'(we));
      if (we) chk("io_wdata", io_wdata, wd);
      n = 0;
      while (stall_DM === 1'b1 && n < 1000) begin
         n++;
         io_rdy   = (n == rdy_at);
         io_rdata = (n == rdy_at) ? rdata : 32'h0;
         tick();
      end
      io_rdy = 1'b0;
      chk("stall_cycles", 32'(n), 32'(exp_stall));
      chk("io_req_drop", 32'(io_req), 32'd0);
      chk("io_err_done", 32'(io_err), 32'(exp_err));
      chk("re_EX_DM_done", 32'(dm_re_EX_DM), 32'(re & ~we));
      drive(1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      // Reset state
      tick(); tick();
      chk("rst_re_EX_DM", 32'(dm_re_EX_DM), 32'd0);
      chk("rst_rd_data", dm_rd_data_EX_DM, 32'd0);
      chk("rst_stall", 32'(stall_DM), 32'd0);
      chk("rst_io_req", 32'(io_req), 32'd0);
      chk("rst_io_we_err", 32'({io_we, io_err}), 32'd0);
      chk("rst_io_bus", io_wdata | 32'(io_addr), 32'd0);
      rst = 1'b0;
      tick();

      // RAM store then load of the same word
      ram_op(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678);
      exp_q.push_back(32'h1234_5678);
      ram_op(1'b1, 1'b0, 32'h0000_0010, 32'h0);
      tick();
      chk("ram_idle_re", 32'(dm_re_EX_DM), 32'd0);

      // Upper address bits ignored; 0xBFFF is RAM and aliases index 0x3FFF
      ram_op(1'b0, 1'b1, 32'h0001_0010, 32'h1111_2222);
      ram_op(1'b0, 1'b1, 32'h0000_BFFF, 32'h0BAD_F00D);
      exp_q.push_back(32'h1111_2222);
      ram_op(1'b1, 1'b0, 32'h0000_0010, 32'h0);
      exp_q.push_back(32'h0BAD_F00D);
      ram_op(1'b1, 1'b0, 32'h0000_3FFF, 32'h0);

      // re and we together act as a store
      ram_op(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055);
      chk("rewe_re_EX_DM", 32'(dm_re_EX_DM), 32'd0);
      chk("rewe_rd_data", dm_rd_data_EX_DM, 32'd0);
      exp_q.push_back(32'h0000_0055);
      ram_op(1'b1, 1'b0, 32'h0000_0020, 32'h0);
      tick();

      // I/O load acked in the third wait cycle
      exp_q.push_back(32'hA5A5_A5A5);
      io_access(1'b1, 1'b0, 32'h0000_C004, 32'h0, 3, 32'hA5A5_A5A5, 3, 1'b0);
      tick();

      // I/O load that never acks
      exp_q.push_back(32'hDEAD_BEEF);
      io_access(1'b1, 1'b0, 32'h0000_C000, 32'h0, 0, 32'h0, TO, 1'b1);
      tick();
      chk("io_err_pulse_end", 32'(io_err), 32'd0);

      // Ack in the final cycle beats the timeout
      exp_q.push_back(32'h1357_9BDF);
      io_access(1'b1, 1'b0, 32'h0000_FFFC, 32'h0, TO, 32'h1357_9BDF, TO, 1'b0);
      tick();

      // Back-to-back I/O store then load
      io_access(1'b0, 1'b1, 32'h0000_C008, 32'h0000_0077, 2, 32'hFFFF_FFFF, 2, 1'b0);
      chk("b2b_store_data", dm_rd_data_EX_DM, 32'd0);
      exp_q.push_back(32'h2468_ACE0);
      io_access(1'b1, 1'b0, 32'h0000_C00C, 32'h0, 1, 32'h2468_ACE0, 1, 1'b0);
      tick();

      // Reset in the middle of an I/O wait
      drive(1'b1, 1'b0, 32'h0000_C010, 32'h0);
      tick(); tick();
      chk("mid_wait_stall", 32'(stall_DM), 32'd1);
      rst = 1'b1;
      tick();
      chk("rst_abort_io_req", 32'(io_req), 32'd0);
      chk("rst_abort_stall", 32'(stall_DM), 32'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      rst = 1'b0;
      tick(); tick();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
